btn_conditioner: RTL and testbench

Input conditioner for the board push-buttons, sitting directly upstream of `top`'s `btn` bus. It synchronises the raw active-high button levels, debounces each one independently, and produces clean level, press, release and auto-repeat strobes. `top` consumes the single-cycle strobes instead of raw key levels. The board wrapper keeps doing the `~KEY` inversion.

---
 rtl/btn_pkg.sv | 20 ++
 rtl/btn_channel.sv | 111 +++++++++++
 rtl/btn_conditioner.sv | 49 ++++
 tb/tb_btn_conditioner.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and helpers for the push-button conditioner.
// Hold-state encoding and counter sizing live here.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT,
    REPEAT_OFF
  } hold_state_t;

  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchroniser, debounce counter
// and hold FSM producing press/release/repeat strobes.
module btn_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o
);

  localparam int DW = cnt_width(DEBOUNCE_CYCLES);
  localparam int RW = cnt_width(imax(REPEAT_DELAY, REPEAT_PERIOD));
  localparam int RDT = (REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0;

  localparam logic [DW-1:0] D_TC  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RD_TC = RW'(RDT);
  localparam logic [RW-1:0] RP_TC = RW'(REPEAT_PERIOD - 1);

  logic          s1_q, s2_q;
  logic          level_q, level_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [RW-1:0] rcnt_q;
  logic          press_q, release_q, repeat_q;
  logic          rise, fall;
  hold_state_t   state_q;

  always_comb begin
    dcnt_d  = dcnt_q;
    level_d = level_q;
    if (s2_q == level_q) begin
      dcnt_d = '0;
    end else if (dcnt_q == D_TC) begin
      level_d = s2_q;
      dcnt_d  = '0;
    end else begin
      dcnt_d = dcnt_q + DW'(1);
    end
  end

  assign rise = level_d & ~level_q;
  assign fall = ~level_d & level_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      level_q   <= 1'b0;
      dcnt_q    <= '0;
      rcnt_q    <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
      state_q   <= IDLE;
    end else begin
      s1_q      <= raw_i;
      s2_q      <= s1_q;
      level_q   <= level_d;
      dcnt_q    <= dcnt_d;
      press_q   <= rise;
      release_q <= fall;
      repeat_q  <= 1'b0;
      // A release wins over a repeat terminal count on the same edge.
      if (fall) begin
        state_q <= IDLE;
        rcnt_q  <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (rise) begin
              rcnt_q  <= '0;
              state_q <= (REPEAT_DELAY == 0) ? REPEAT_OFF : HOLD;
            end
          end
          HOLD: begin
            if (rcnt_q == RD_TC) begin
              repeat_q <= 1'b1;
              rcnt_q   <= '0;
              state_q  <= REPEAT;
            end else begin
              rcnt_q <= rcnt_q + RW'(1);
            end
          end
          REPEAT: begin
            if (rcnt_q == RP_TC) begin
              repeat_q <= 1'b1;
              rcnt_q   <= '0;
            end else begin
              rcnt_q <= rcnt_q + RW'(1);
            end
          end
          REPEAT_OFF: ;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign repeat_o  = repeat_q;

endmodule

// File: rtl/btn_conditioner.sv
// Push-button conditioner: N independent debounced channels
// with press, release and auto-repeat strobes.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int N               = 3,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 5_000_000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] btn_raw,
  output logic [N-1:0] btn_level,
  output logic [N-1:0] btn_press,
  output logic [N-1:0] btn_release,
  output logic [N-1:0] btn_repeat
);

  if (N < 1) begin : g_bad_n
    $fatal(1, "btn_conditioner: N must be >= 1");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
    $fatal(1, "btn_conditioner: DEBOUNCE_CYCLES must be >= 1");
  end
  if (REPEAT_DELAY < 0) begin : g_bad_rd
    $fatal(1, "btn_conditioner: REPEAT_DELAY must be >= 0");
  end
  if (REPEAT_PERIOD < 1) begin : g_bad_rp
    $fatal(1, "btn_conditioner: REPEAT_PERIOD must be >= 1");
  end

  for (genvar i = 0; i < N; i++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .raw_i    (btn_raw[i]),
      .level_o  (btn_level[i]),
      .press_o  (btn_press[i]),
      .release_o(btn_release[i]),
      .repeat_o (btn_repeat[i])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed scenarios plus random
// stimulus against a run-length behavioural model.
module tb_btn_conditioner;

  localparam int N  = 3;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] btn_raw = '0;
  logic [1:0][N-1:0] lv, pr, rl, rp;

  int total = 0;
  int bad = 0;
  bit chk_on = 0;

  always #5 clk = ~clk;

  btn_conditioner #(
    .N(N), .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw),
    .btn_level(lv[0]), .btn_press(pr[0]),
    .btn_release(rl[0]), .btn_repeat(rp[0])
  );

  btn_conditioner #(
    .N(N), .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY(0), .REPEAT_PERIOD(RP)
  ) dut_nr (
    .clk(clk), .rst(rst), .btn_raw(btn_raw),
    .btn_level(lv[1]), .btn_press(pr[1]),
    .btn_release(rl[1]), .btn_repeat(rp[1])
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // Reference: raw is seen two edges late; level flips after DB
  // consecutive differing samples; repeats by time since press.
  int run[2][N];
  int since[2][N];
  bit ml[2][N];
  bit act[2][N];
  bit h1[N], h2[N];
  logic [1:0][N-1:0] el, ep, er, eq;
  int rdv[2] = '{RD, 0};

  always @(posedge clk) begin
    bit sy;
    for (int c = 0; c < N; c++) begin
      if (rst) begin
        h1[c] = 0;
        h2[c] = 0;
        for (int d = 0; d < 2; d++) begin
          run[d][c] = 0; since[d][c] = 0;
          ml[d][c] = 0; act[d][c] = 0;
          el[d][c] = 0; ep[d][c] = 0;
          er[d][c] = 0; eq[d][c] = 0;
        end
      end else begin
        sy = h2[c];
        h2[c] = h1[c];
        h1[c] = btn_raw[c];
        for (int d = 0; d < 2; d++) begin
          ep[d][c] = 0; er[d][c] = 0; eq[d][c] = 0;
          if (sy != ml[d][c]) begin
            run[d][c]++;
            if (run[d][c] == DB) begin
              ml[d][c] = sy;
              run[d][c] = 0;
              if (sy) ep[d][c] = 1;
              else er[d][c] = 1;
            end
          end else begin
            run[d][c] = 0;
          end
          if (ep[d][c]) begin
            since[d][c] = 0;
            act[d][c] = (rdv[d] != 0);
          end else if (er[d][c]) begin
            act[d][c] = 0;
          end else if (act[d][c]) begin
            since[d][c]++;
            if (since[d][c] == rdv[d] ||
                (since[d][c] > rdv[d] &&
                 (since[d][c] - rdv[d]) % RP == 0))
              eq[d][c] = 1;
          end
          el[d][c] = ml[d][c];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("m_lvl%0d", d), 32'(lv[d]), 32'(el[d]));
        chk($sformatf("m_prs%0d", d), 32'(pr[d]), 32'(ep[d]));
        chk($sformatf("m_rel%0d", d), 32'(rl[d]), 32'(er[d]));
        chk($sformatf("m_rep%0d", d), 32'(rp[d]), 32'(eq[d]));
      end
    end
  end

  task automatic wait_press(input int ch, input int d,
                            output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (pr[d][ch]) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic idle(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_lvl"}, 32'({lv[1], lv[0]}), 0);
    chk({tag, "_prs"}, 32'({pr[1], pr[0]}), 0);
    chk({tag, "_rel"}, 32'({rl[1], rl[0]}), 0);
    chk({tag, "_rep"}, 32'({rp[1], rp[0]}), 0);
  endtask

  int n, cnt, cnt2, cnt3, post;
  bit seen;
  int left[N];

  initial begin
    rst = 1'b1;
    idle(3);
    chk_on = 1;
    all_zero("reset");
    rst = 1'b0;
    idle(5);

    // clean press on ch0
    btn_raw[0] = 1'b1;
    wait_press(0, 0, n);
    chk("press_lat", n, DB + 2);
    chk("press_lvl", 32'(lv[0]), 32'b001);
    idle(1);
    chk("press_one", 32'(pr[0][0]), 0);

    // auto-repeat while held, then release
    cnt = 0;
    for (int k = 2; k <= 30; k++) begin
      @(negedge clk);
      if (rp[0][0]) cnt++;
      if (rp[0][0] && pr[0][0]) chk("prs_rep", 1, 0);
    end
    chk("rep_cnt", cnt, 7);
    btn_raw[0] = 1'b0;
    cnt = 0; post = 0; seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (seen && rp[0][0]) post++;
      if (rl[0][0]) begin cnt++; seen = 1; end
    end
    chk("rel_cnt", cnt, 1);
    chk("rep_after_rel", post, 0);

    // bounce on ch1: 3-high/2-low twice, then held
    cnt = 0;
    for (int b = 0; b < 2; b++) begin
      btn_raw[1] = 1'b1;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk); if (pr[0][1] | rl[0][1]) cnt++;
      end
      btn_raw[1] = 1'b0;
      for (int i = 0; i < 2; i++) begin
        @(negedge clk); if (pr[0][1] | rl[0][1]) cnt++;
      end
    end
    idle(4);
    chk("bounce_strobes", cnt, 0);
    btn_raw[1] = 1'b1;
    wait_press(1, 0, n);
    chk("bounce_lat", n, DB + 2);

    // release lands on the repeat edge P+13
    btn_raw[0] = 1'b1;
    wait_press(0, 0, n);
    chk("coll_press", n, DB + 2);
    idle(7);
    btn_raw[0] = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 3) chk("coll_first_rep", 32'(rp[0][0]), 1);
      if (i == 6) begin
        chk("coll_rel", 32'(rl[0][0]), 1);
        chk("coll_rep", 32'(rp[0][0]), 0);
      end
    end

    // reset during debounce and during repeat
    btn_raw[2] = 1'b1;
    idle(2);
    rst = 1'b1;
    idle(1);
    all_zero("rst_db");
    rst = 1'b0;
    wait_press(2, 0, n);
    chk("rst_db_lat", n, DB + 2);
    idle(12);
    rst = 1'b1;
    idle(1);
    all_zero("rst_rep");
    rst = 1'b0;
    wait_press(2, 0, n);
    chk("rst_rep_lat", n, DB + 2);
    btn_raw = '0;
    idle(15);

    // repeat disabled instance: 50-cycle hold
    cnt = 0; cnt2 = 0; cnt3 = 0;
    btn_raw[0] = 1'b1;
    for (int i = 0; i < 65; i++) begin
      if (i == 50) btn_raw[0] = 1'b0;
      @(negedge clk);
      cnt  += int'(pr[1][0]);
      cnt2 += int'(rp[1][0]);
      cnt3 += int'(rl[1][0]);
    end
    chk("nr_press", cnt, 1);
    chk("nr_rep", cnt2, 0);
    chk("nr_rel", cnt3, 1);

    // random hold lengths and occasional resets
    for (int c = 0; c < N; c++) left[c] = $urandom_range(1, 12);
    for (int t = 0; t < 4000; t++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 399) == 0);
      for (int c = 0; c < N; c++) begin
        left[c]--;
        if (left[c] == 0) begin
          btn_raw[c] = ~btn_raw[c];
          left[c] = ($urandom_range(0, 3) == 0)
                    ? $urandom_range(20, 40)
                    : $urandom_range(1, 8);
        end
      end
    end
    rst = 1'b0;
    btn_raw = '0;
    idle(20);
    chk_on = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
